// File: rtl/multi_ch_acq_core.sv
// ---------------------------------------------------------------------------
// multi_ch_acq_core
//
// Multi-channel triggered acquisition core. After ARM, decimated samples of
// every channel are written into a shared circular buffer. PRETRIG samples
// are gathered first; the core then waits for a level crossing on the
// selected channel (or a forced trigger). After the trigger it fills the rest
// of the buffer and presents the capture for random-access readout. Logical
// read index 0 is always the oldest sample of the capture.
//
// Ports
//   SYS_CLK      in   sole clock, rising edge
//   RESET        in   asynchronous active-high reset
//   ADC_DATA     in   NUM_CH*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   ADC_OR       in   NUM_CH per-channel over-range flags
//   ARM          in   single-cycle capture start (accepted in IDLE/DONE only)
//   FORCE_TRIG   in   trigger request, honoured in WAIT_TRIG
//   PRESCALE     in   keep one sample every PRESCALE+1 cycles
//   TRIG_CH      in   trigger source channel
//   TRIG_LEVEL   in   trigger threshold (offset-binary unsigned)
//   TRIG_SLOPE   in   0 rising, 1 falling
//   PRETRIG      in   samples kept ahead of the trigger sample
//   RD_EN        in   read request (served in DONE)
//   RD_ADDR      in   logical read index, 0 = oldest
//   RD_DATA      out  all channels of the addressed sample
//   RD_VALID     out  RD_DATA qualifier, one cycle after RD_EN
//   BUFFER_READY out  capture complete
//   OVERRANGE    out  sticky per-channel over-range seen during capture
//   STATE        out  FSM state code
// ---------------------------------------------------------------------------
module multi_ch_acq_core #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 14,
  parameter int DEPTH_LOG2 = 10,
  parameter int PRESC_W    = 7
) (
  input  logic                                             SYS_CLK,
  input  logic                                             RESET,
  input  logic [NUM_CH*DATA_W-1:0]                         ADC_DATA,
  input  logic [NUM_CH-1:0]                                ADC_OR,
  input  logic                                             ARM,
  input  logic                                             FORCE_TRIG,
  input  logic [PRESC_W-1:0]                               PRESCALE,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   TRIG_CH,
  input  logic [DATA_W-1:0]                                TRIG_LEVEL,
  input  logic                                             TRIG_SLOPE,
  input  logic [DEPTH_LOG2-1:0]                            PRETRIG,
  input  logic                                             RD_EN,
  input  logic [DEPTH_LOG2-1:0]                            RD_ADDR,
  output logic [NUM_CH*DATA_W-1:0]                         RD_DATA,
  output logic                                             RD_VALID,
  output logic                                             BUFFER_READY,
  output logic [NUM_CH-1:0]                                OVERRANGE,
  output logic [2:0]                                       STATE
);

  localparam int TCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int WORD_W = NUM_CH * DATA_W;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Trigger-source channel out of the packed ADC word; an index beyond
  // NUM_CH (non power-of-two channel counts) reads as zero.
  function automatic logic [DATA_W-1:0] sel_ch(input logic [WORD_W-1:0] d,
                                               input logic [TCH_W-1:0]  ch);
    sel_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(ch) == k) sel_ch = d[k*DATA_W +: DATA_W];
    end
  endfunction

  function automatic logic crossed(input logic [DATA_W-1:0] prev,
                                   input logic [DATA_W-1:0] cur,
                                   input logic [DATA_W-1:0] lvl,
                                   input logic              falling);
    if (falling) crossed = (prev > lvl) && (cur <= lvl);
    else         crossed = (prev < lvl) && (cur >= lvl);
  endfunction

  // Control state
  state_t                  state_q,      state_d;
  logic [PRESC_W-1:0]      dcnt_q,       dcnt_d;
  logic [DEPTH_LOG2-1:0]   wptr_q,       wptr_d;
  logic [DEPTH_LOG2-1:0]   pre_cnt_q,    pre_cnt_d;
  logic [DEPTH_LOG2-1:0]   post_left_q,  post_left_d;
  logic [DEPTH_LOG2-1:0]   start_q,      start_d;
  logic                    have_prev_q,  have_prev_d;
  logic                    force_pend_q, force_pend_d;
  logic [NUM_CH-1:0]       ovr_q,        ovr_d;

  // Configuration latched on ARM, plus previous trigger-channel sample
  logic [PRESC_W-1:0]      presc_q;
  logic [TCH_W-1:0]        trig_ch_q;
  logic [DATA_W-1:0]       level_q;
  logic                    slope_q;
  logic [DEPTH_LOG2-1:0]   pretrig_q;
  logic [DATA_W-1:0]       prev_q,       prev_d;
  logic                    cfg_load;

  // Buffer and read port
  logic [WORD_W-1:0]       mem_q [DEPTH];
  logic                    mem_we;
  logic                    rd_hit;
  logic [DEPTH_LOG2-1:0]   rd_phys;
  logic [WORD_W-1:0]       rd_data_q;
  logic                    rd_valid_q;

  logic                    capturing;
  logic                    strobe;
  logic [DATA_W-1:0]       cur_sample;
  logic                    trig_hit;

  assign capturing  = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  // Decimation counter restarts at zero on ARM, so the first capture cycle strobes.
  assign strobe     = capturing && (dcnt_q == '0);
  assign cur_sample = sel_ch(ADC_DATA, trig_ch_q);
  // A forced trigger also fires when it coincides with the strobe itself.
  assign trig_hit   = (have_prev_q && crossed(prev_q, cur_sample, level_q, slope_q))
                      || force_pend_q || FORCE_TRIG;
  assign rd_phys    = start_q + RD_ADDR;

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    wptr_d       = wptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_left_d  = post_left_q;
    start_d      = start_q;
    have_prev_d  = have_prev_q;
    force_pend_d = force_pend_q;
    ovr_d        = ovr_q;
    prev_d       = prev_q;
    cfg_load     = 1'b0;
    mem_we       = 1'b0;
    rd_hit       = 1'b0;

    if (capturing) begin
      dcnt_d = (dcnt_q == presc_q) ? '0 : dcnt_q + 1'b1;
    end

    if (strobe) begin
      mem_we      = 1'b1;
      wptr_d      = wptr_q + 1'b1;
      ovr_d       = ovr_q | ADC_OR;
      prev_d      = cur_sample;
      have_prev_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ARM) begin
          cfg_load     = 1'b1;
          dcnt_d       = '0;
          wptr_d       = '0;
          pre_cnt_d    = '0;
          post_left_d  = '0;
          have_prev_d  = 1'b0;
          force_pend_d = 1'b0;
          ovr_d        = '0;
          state_d      = (PRETRIG != '0) ? ST_PRE : ST_WAIT;
        end else if (state_q == ST_DONE && RD_EN) begin
          rd_hit = 1'b1;
        end
      end

      ST_PRE: begin
        if (strobe) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if ((pre_cnt_q + 1'b1) == pretrig_q) state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (FORCE_TRIG) force_pend_d = 1'b1;
        if (strobe && trig_hit) begin
          force_pend_d = 1'b0;
          start_d      = wptr_q - pretrig_q;
          // Samples still owed after the trigger: DEPTH-1-PRETRIG == ~PRETRIG.
          post_left_d  = ~pretrig_q;
          state_d      = (~pretrig_q == '0) ? ST_DONE : ST_POST;
        end
      end

      ST_POST: begin
        if (strobe) begin
          post_left_d = post_left_q - 1'b1;
          if (post_left_q == PTR_ONE) state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      dcnt_q       <= '0;
      wptr_q       <= '0;
      pre_cnt_q    <= '0;
      post_left_q  <= '0;
      start_q      <= '0;
      have_prev_q  <= 1'b0;
      force_pend_q <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      wptr_q       <= wptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_left_q  <= post_left_d;
      start_q      <= start_d;
      have_prev_q  <= have_prev_d;
      force_pend_q <= force_pend_d;
      ovr_q        <= ovr_d;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    prev_q <= prev_d;
    if (cfg_load) begin
      presc_q   <= PRESCALE;
      trig_ch_q <= TRIG_CH;
      level_q   <= TRIG_LEVEL;
      slope_q   <= TRIG_SLOPE;
      pretrig_q <= PRETRIG;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (mem_we) mem_q[wptr_q] <= ADC_DATA;
  end

  // Registered read: RD_DATA holds its last value whenever no read is served.
  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      if (rd_hit) rd_data_q <= mem_q[rd_phys];
    end
  end

  assign RD_DATA      = rd_data_q;
  assign RD_VALID     = rd_valid_q;
  assign BUFFER_READY = (state_q == ST_DONE);
  assign OVERRANGE    = ovr_q;
  assign STATE        = state_q;

endmodule

// File: doc/multi_ch_acq_core.md
MULTI_CH_ACQ_CORE -- requirements
Module: multi_ch_acq_core

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of ADC channels.
REQ-002 SHALL have parameter DATA_W, default 14: sample width per channel, offset-binary unsigned.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: buffer depth DEPTH = 2^DEPTH_LOG2 samples per channel.
REQ-004 SHALL have parameter PRESC_W, default 7: decimation control width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: SYS_CLK, input, 1, sole clock, all logic on its rising edge.
REQ-006 SHALL have RESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ADC_DATA, input, NUM_CH*DATA_W, channel k in bits [k*DATA_W +: DATA_W], already synchronous to SYS_CLK.
REQ-008 SHALL have ADC_OR, input, NUM_CH, per-channel over-range flags.
REQ-009 SHALL have ARM, input, 1, single-cycle start-capture pulse.
REQ-010 SHALL have FORCE_TRIG, input, 1, immediate trigger request.
REQ-011 SHALL have PRESCALE, input, PRESC_W, keep one sample every PRESCALE+1 cycles.
REQ-012 SHALL have TRIG_CH, input, clog2(NUM_CH) (min 1), trigger source channel.
REQ-013 SHALL have TRIG_LEVEL, input, DATA_W, trigger threshold.
REQ-014 SHALL have TRIG_SLOPE, input, 1: 0 rising, 1 falling.
REQ-015 SHALL have PRETRIG, input, DEPTH_LOG2, samples kept before trigger.
REQ-016 SHALL have RD_EN, input, 1, read request.
REQ-017 SHALL have RD_ADDR, input, DEPTH_LOG2, logical index, 0 = oldest sample.
REQ-018 SHALL have RD_DATA, output, NUM_CH*DATA_W, read data, all channels.
REQ-019 SHALL have RD_VALID, output, 1, RD_DATA qualifier.
REQ-020 SHALL have BUFFER_READY, output, 1, capture complete.
REQ-021 SHALL have OVERRANGE, output, NUM_CH, sticky per-channel over-range during capture.
REQ-022 SHALL have STATE, output, 3, current FSM state code.

Function
REQ-023 SHALL implement FSM IDLE(0), PRE(1), WAIT_TRIG(2), POST(3), DONE(4).
REQ-024 SHALL latch PRESCALE, TRIG_CH, TRIG_LEVEL, TRIG_SLOPE, PRETRIG on the ARM cycle; later input changes have no effect until the next ARM.
REQ-025 SHALL, on ARM in IDLE or DONE, clear write pointer, decimation counter, OVERRANGE, BUFFER_READY and enter PRE (PRETRIG>0) or WAIT_TRIG (PRETRIG=0); ARM in PRE/WAIT_TRIG/POST SHALL be ignored.
REQ-026 SHALL generate a sample strobe on the first cycle after entering PRE/WAIT_TRIG and then every PRESCALE+1 cycles; PRESCALE=0 gives a strobe every cycle.
REQ-027 SHALL on each strobe write all NUM_CH samples to the circular buffer at the write pointer and increment it modulo DEPTH.
REQ-028 SHALL move PRE->WAIT_TRIG after PRETRIG strobes; in WAIT_TRIG the buffer wraps freely.
REQ-029 SHALL detect rising trigger when prev < TRIG_LEVEL and cur >= TRIG_LEVEL, falling when prev > TRIG_LEVEL and cur <= TRIG_LEVEL, on strobed TRIG_CH samples; the first WAIT_TRIG strobe with PRETRIG=0 only loads prev.
REQ-030 SHALL treat FORCE_TRIG in WAIT_TRIG as a trigger on the next strobe; FORCE_TRIG in other states SHALL be ignored.
REQ-031 SHALL store the trigger sample at logical index PRETRIG, record start = trigger address - PRETRIG mod DEPTH, enter POST.
REQ-032 SHALL in POST write DEPTH-PRETRIG-1 further samples, then enter DONE with BUFFER_READY=1 in the same cycle as the state change.
REQ-033 SHALL OR ADC_OR into OVERRANGE on every strobe in PRE/WAIT_TRIG/POST.
REQ-034 SHALL in DONE return buffer[(start + RD_ADDR) mod DEPTH] on RD_DATA with RD_VALID=1 exactly one cycle after RD_EN; back-to-back reads give one result per cycle.
REQ-035 SHALL hold RD_VALID=0 for RD_EN outside DONE; RD_EN and ARM in the same DONE cycle: ARM wins, RD_VALID=0 next cycle.
REQ-036 SHALL hold RD_DATA stable when RD_VALID=0.

Reset
REQ-037 SHALL on RESET force STATE=IDLE, BUFFER_READY=0, RD_VALID=0, RD_DATA=0, OVERRANGE=0, all pointers/counters 0, mid-capture included; buffer contents are not cleared.

Verification
REQ-038 Ramp 0..4095 on ch0, PRESCALE=0, PRETRIG=100, LEVEL=2000 rising, DEPTH=1024 -> RD_ADDR 100 returns 2000, RD_ADDR 0 returns 1900, RD_ADDR 1023 returns 2923.
REQ-039 PRESCALE=3, same ramp -> consecutive stored samples differ by 4, strobe every 4 cycles.
REQ-040 PRETRIG=0, constant 500 input, FORCE_TRIG pulse -> DONE after 1024 strobes, RD_ADDR 0 = 500.
REQ-041 Falling slope, sine crossing LEVEL -> trigger sample <= LEVEL, preceding sample > LEVEL.
REQ-042 ADC_OR[1] pulsed in POST -> OVERRANGE=2'b10 until next ARM.
REQ-043 RESET asserted in POST -> STATE=0, BUFFER_READY=0 same cycle; ARM after release restarts cleanly.
